// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle KGP-RISC control FSM with memory handshake and illegal detection
// Define ILLEGAL_TRAP_EN to park illegal instructions in TRAP; otherwise they retire as NOPs.
module multicycle_control_unit #(
  parameter int OP_W     = 6,
  parameter int FN_W     = 6,
  parameter int ALUCTR_W = 3,
  parameter int MEM_TMO  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FN_W-1:0]     fn,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic                mem_req,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic                regwrite,
  output logic [1:0]          regdst,
  output logic [1:0]          alusrc,
  output logic [ALUCTR_W-1:0] aluctr,
  output logic [1:0]          flag,
  output logic                branch,
  output logic                brnoeq,
  output logic                gotoreg,
  output logic                onlygoto,
  output logic                call,
  output logic                ret,
  output logic [2:0]          state,
  output logic                mem_tmo,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_BRANCH = 3'b101,
    S_TRAP   = 3'b110
  } state_t;

  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BR, K_CALL, K_RET, K_NOP} kind_t;

  localparam int CNT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(33);
  localparam logic [OP_W-1:0] OP_COMPI = OP_W'(34);
  localparam logic [OP_W-1:0] OP_SHLL  = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SHRL  = OP_W'(36);
  localparam logic [OP_W-1:0] OP_SHRA  = OP_W'(37);
  localparam logic [OP_W-1:0] OP_BC0   = OP_W'(49);
  localparam logic [OP_W-1:0] OP_BC1   = OP_W'(50);
  localparam logic [OP_W-1:0] OP_BC2   = OP_W'(51);
  localparam logic [OP_W-1:0] OP_BC3   = OP_W'(52);
  localparam logic [OP_W-1:0] OP_BC4   = OP_W'(53);
  localparam logic [OP_W-1:0] OP_BC5   = OP_W'(54);
  localparam logic [OP_W-1:0] OP_BC6   = OP_W'(55);
  localparam logic [OP_W-1:0] OP_BC7   = OP_W'(56);
  localparam logic [OP_W-1:0] OP_B     = OP_W'(57);
  localparam logic [OP_W-1:0] OP_BR    = OP_W'(58);
  localparam logic [OP_W-1:0] OP_RET   = OP_W'(60);
  localparam logic [OP_W-1:0] OP_CALL  = OP_W'(61);

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [FN_W-1:0]     fn_q, fn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_tmo_q, mem_tmo_d;
  logic                illegal_q, illegal_d;
  logic [ALUCTR_W-1:0] aluctr_q, aluctr_d;
  logic [1:0]          alusrc_q, alusrc_d;
  logic [1:0]          regdst_q, regdst_d;
  logic [1:0]          flag_q, flag_d;
  logic                brnoeq_q, brnoeq_d;
  logic                memtoreg_q, memtoreg_d;
  logic                gotoreg_q, gotoreg_d;
  logic                onlygoto_q, onlygoto_d;

  kind_t               dec_kind;
  logic                dec_illegal;
  logic [ALUCTR_W-1:0] dec_aluctr;
  logic [1:0]          dec_alusrc, dec_regdst, dec_flag;
  logic                dec_brnoeq, dec_memtoreg, dec_gotoreg, dec_onlygoto;

  // Decode of the latched instruction word; only consumed while in DECODE.
  always_comb begin
    dec_kind     = K_NOP;
    dec_illegal  = 1'b0;
    dec_aluctr   = '0;
    dec_alusrc   = 2'b00;
    dec_regdst   = 2'b00;
    dec_flag     = 2'b00;
    dec_brnoeq   = 1'b0;
    dec_memtoreg = 1'b0;
    dec_gotoreg  = 1'b0;
    dec_onlygoto = 1'b0;
    case (op_q)
      OP_RTYPE: begin
        if (fn_q >= FN_W'(1) && fn_q <= FN_W'(7)) begin
          dec_kind   = K_ALU;
          dec_aluctr = ALUCTR_W'(fn_q[2:0]);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_kind     = K_LOAD;
        dec_regdst   = 2'b01;
        dec_alusrc   = 2'b01;
        dec_aluctr   = ALUCTR_W'(3'b001);
        dec_memtoreg = 1'b1;
      end
      OP_STORE: begin
        dec_kind   = K_STORE;
        dec_alusrc = 2'b01;
        dec_aluctr = ALUCTR_W'(3'b001);
      end
      OP_ADDI:  begin dec_kind = K_ALU; dec_alusrc = 2'b10; dec_aluctr = ALUCTR_W'(3'b001); end
      OP_COMPI: begin dec_kind = K_ALU; dec_alusrc = 2'b10; dec_aluctr = ALUCTR_W'(3'b000); end
      OP_SHLL:  begin dec_kind = K_ALU; dec_alusrc = 2'b10; dec_aluctr = ALUCTR_W'(3'b101); end
      OP_SHRL:  begin dec_kind = K_ALU; dec_alusrc = 2'b10; dec_aluctr = ALUCTR_W'(3'b110); end
      OP_SHRA:  begin dec_kind = K_ALU; dec_alusrc = 2'b10; dec_aluctr = ALUCTR_W'(3'b111); end
      OP_BC0, OP_BC1: begin dec_kind = K_BR; dec_flag = 2'b00; dec_brnoeq = op_q[0]; end
      OP_BC2, OP_BC3: begin dec_kind = K_BR; dec_flag = 2'b01; dec_brnoeq = op_q[0]; end
      OP_BC4, OP_BC5: begin dec_kind = K_BR; dec_flag = 2'b11; dec_brnoeq = op_q[0]; end
      OP_BC6, OP_BC7: begin dec_kind = K_BR; dec_flag = 2'b10; dec_brnoeq = op_q[0]; end
      OP_B:     begin dec_kind = K_BR; dec_onlygoto = 1'b1; end
      OP_BR:    begin dec_kind = K_BR; dec_gotoreg = 1'b1; dec_onlygoto = 1'b1; end
      OP_RET:   begin dec_kind = K_RET; dec_gotoreg = 1'b1; dec_onlygoto = 1'b1; end
      OP_CALL:  begin dec_kind = K_CALL; dec_onlygoto = 1'b1; dec_regdst = 2'b10; end
      default:  dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    op_d       = op_q;
    fn_d       = fn_q;
    cnt_d      = cnt_q;
    mem_tmo_d  = mem_tmo_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`else
    illegal_d  = 1'b0;
`endif
    aluctr_d   = aluctr_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    flag_d     = flag_q;
    brnoeq_d   = brnoeq_q;
    memtoreg_d = memtoreg_q;
    gotoreg_d  = gotoreg_q;
    onlygoto_d = onlygoto_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    mem_req    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    branch     = 1'b0;
    call       = 1'b0;
    ret        = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_we   = 1'b1;
          op_d    = opcode;
          fn_d    = fn;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        aluctr_d   = dec_aluctr;
        alusrc_d   = dec_alusrc;
        regdst_d   = dec_regdst;
        flag_d     = dec_flag;
        brnoeq_d   = dec_brnoeq;
        memtoreg_d = dec_memtoreg;
        gotoreg_d  = dec_gotoreg;
        onlygoto_d = dec_onlygoto;
        kind_d     = dec_kind;
        cnt_d      = '0;
        if (dec_illegal) begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
`else
          state_d   = S_WB;
`endif
        end else if (dec_kind == K_ALU) begin
          state_d = S_EXEC;
        end else if (dec_kind == K_LOAD || dec_kind == K_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_BRANCH;
        end
      end
      S_EXEC: state_d = S_WB;
      S_MEM: begin
        mem_req  = 1'b1;
        memread  = (kind_q == K_LOAD);
        memwrite = (kind_q == K_STORE);
        if (mem_ready) begin
          cnt_d = '0;
          if (kind_q == K_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (MEM_TMO != 0 && cnt_q == CNT_W'(MEM_TMO - 1)) begin
          // This cycle is the MEM_TMO-th wait: abandon the access and move on.
          mem_tmo_d = 1'b1;
          pc_we     = 1'b1;
          cnt_d     = '0;
          state_d   = S_FETCH;
        end else if (MEM_TMO != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        regwrite = (kind_q != K_NOP);
        pc_we    = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        branch   = 1'b1;
        pc_we    = 1'b1;
        call     = (kind_q == K_CALL);
        regwrite = (kind_q == K_CALL);
        ret      = (kind_q == K_RET);
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      kind_q     <= K_ALU;
      op_q       <= '0;
      fn_q       <= '0;
      cnt_q      <= '0;
      mem_tmo_q  <= 1'b0;
      illegal_q  <= 1'b0;
      aluctr_q   <= '0;
      alusrc_q   <= 2'b00;
      regdst_q   <= 2'b00;
      flag_q     <= 2'b00;
      brnoeq_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      gotoreg_q  <= 1'b0;
      onlygoto_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      op_q       <= op_d;
      fn_q       <= fn_d;
      cnt_q      <= cnt_d;
      mem_tmo_q  <= mem_tmo_d;
      illegal_q  <= illegal_d;
      aluctr_q   <= aluctr_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      flag_q     <= flag_d;
      brnoeq_q   <= brnoeq_d;
      memtoreg_q <= memtoreg_d;
      gotoreg_q  <= gotoreg_d;
      onlygoto_q <= onlygoto_d;
    end
  end

  assign state    = state_q;
  assign mem_tmo  = mem_tmo_q;
  assign illegal  = illegal_q;
  assign aluctr   = aluctr_q;
  assign alusrc   = alusrc_q;
  assign regdst   = regdst_q;
  assign flag     = flag_q;
  assign brnoeq   = brnoeq_q;
  assign memtoreg = memtoreg_q;
  assign gotoreg  = gotoreg_q;
  assign onlygoto = onlygoto_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
// Expected per-cycle outputs are queued with their stimulus and compared at the falling edge.
module tb_multicycle_control_unit;

  localparam logic [2:0] S_FE = 3'd0, S_DE = 3'd1, S_EX = 3'd2, S_ME = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_BR = 3'd5, S_TR = 3'd6;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we, pc_we, mem_req, memread, memwrite, memtoreg, regwrite;
    logic       branch, brnoeq, gotoreg, onlygoto, call, ret, mem_tmo, illegal;
    logic [1:0] regdst, alusrc;
    logic [2:0] aluctr;
    logic [1:0] flag;
  } exp_t;

  typedef struct {
    exp_t       e;
    logic       iv;
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n, instr_valid, mem_ready;
  logic [5:0] opcode, fn;
  logic       ir_we, pc_we, mem_req, memread, memwrite, memtoreg, regwrite;
  logic [1:0] regdst, alusrc, flag;
  logic [2:0] aluctr, state;
  logic       branch, brnoeq, gotoreg, onlygoto, call, ret, mem_tmo, illegal;

  int   checks = 0;
  int   passed = 0;
  ent_t sb[$];
  exp_t hold;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .fn(fn),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .mem_req(mem_req),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
    .regdst(regdst), .alusrc(alusrc), .aluctr(aluctr), .flag(flag), .branch(branch),
    .brnoeq(brnoeq), .gotoreg(gotoreg), .onlygoto(onlygoto), .call(call), .ret(ret),
    .state(state), .mem_tmo(mem_tmo), .illegal(illegal)
  );

  function automatic exp_t obs();
    exp_t o;
    o.st = state;         o.ir_we = ir_we;       o.pc_we = pc_we;
    o.mem_req = mem_req;  o.memread = memread;   o.memwrite = memwrite;
    o.memtoreg = memtoreg; o.regwrite = regwrite; o.branch = branch;
    o.brnoeq = brnoeq;    o.gotoreg = gotoreg;   o.onlygoto = onlygoto;
    o.call = call;        o.ret = ret;           o.mem_tmo = mem_tmo;
    o.illegal = illegal;  o.regdst = regdst;     o.alusrc = alusrc;
    o.aluctr = aluctr;    o.flag = flag;
    return o;
  endfunction

  // hold carries only the registered fields and the sticky timeout; enables stay 0 in it
  function automatic exp_t cyc(input logic [2:0] st);
    exp_t e;
    e = hold;
    e.st = st;
    return e;
  endfunction

  task automatic set_fields(input logic [1:0] rd, input logic [1:0] as, input logic [2:0] ac,
                            input logic [1:0] fl, input logic bn, input logic mtr,
                            input logic gr, input logic og);
    hold.regdst = rd;  hold.alusrc = as;   hold.aluctr = ac;  hold.flag = fl;
    hold.brnoeq = bn;  hold.memtoreg = mtr; hold.gotoreg = gr; hold.onlygoto = og;
  endtask

  task automatic push(input exp_t e, input logic iv, input logic mr,
                      input logic [5:0] op, input logic [5:0] f);
    ent_t x;
    x.e = e; x.iv = iv; x.mr = mr; x.op = op; x.fn = f;
    sb.push_back(x);
  endtask

  // FETCH with a valid word, then DECODE with a conflicting word and mem_ready that must be ignored
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] f);
    exp_t e;
    e = cyc(S_FE);
    e.ir_we = 1'b1;
    push(e, 1'b1, 1'b0, op, f);
    push(cyc(S_DE), 1'b1, 1'b1, ~op, ~f);
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; opcode = '0; fn = '0;
    hold = '0;
    repeat (2) @(posedge clk);
    #1 o = obs();
    checks++;
    if (o !== exp_t'(0)) $display("FAIL reset_held: got %h, expected %h", o, exp_t'(0));
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    o = obs();
    checks++;
    if (o !== exp_t'(0)) $display("FAIL reset_release: got %h, expected %h", o, exp_t'(0));
    else passed++;
  endtask

  task automatic test_rtype();
    logic [5:0] fns [3];
    exp_t e;
    int n = 0;
    fns = '{6'd3, 6'd7, 6'd1};
    for (int k = 0; k < 3; k++) begin
      fetch_decode(6'b000000, fns[k]);
      set_fields(2'b00, 2'b00, fns[k][2:0], 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      push(cyc(S_EX), 1'b0, 1'b1, 6'h3f, 6'h00);
      e = cyc(S_WB); e.regwrite = 1'b1; e.pc_we = 1'b1;
      push(e, 1'b0, 1'b0, 6'h3f, 6'h00);
    end
    push(cyc(S_FE), 1'b0, 1'b1, 6'h00, 6'h00);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL rtype cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    exp_t e;
    int n = 0;
    fetch_decode(6'b000001, 6'd0);
    set_fields(2'b01, 2'b01, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    e = cyc(S_ME); e.mem_req = 1'b1; e.memread = 1'b1;
    repeat (3) push(e, 1'b1, 1'b0, 6'd2, 6'd0);
    push(e, 1'b0, 1'b1, 6'd2, 6'd0);
    e = cyc(S_WB); e.regwrite = 1'b1; e.pc_we = 1'b1;
    push(e, 1'b0, 1'b0, 6'd0, 6'd0);
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL load cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [5];
    logic [2:0] acs [5];
    exp_t e;
    int n = 0;
    ops = '{6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101};
    acs = '{3'b001, 3'b000, 3'b101, 3'b110, 3'b111};
    for (int k = 0; k < 5; k++) begin
      fetch_decode(ops[k], 6'd0);
      set_fields(2'b00, 2'b10, acs[k], 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      push(cyc(S_EX), 1'b1, 1'b0, 6'd0, 6'd0);
      e = cyc(S_WB); e.regwrite = 1'b1; e.pc_we = 1'b1;
      push(e, 1'b1, 1'b0, 6'd0, 6'd0);
    end
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL imm cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [8];
    logic [1:0] fls [8];
    logic [1:0] rds [8];
    logic [7:0] bns, grs, ogs, cls, rts;
    exp_t e;
    int n = 0;
    // call, bv, 110001, 110100, 110101, b, br, ret
    ops = '{6'b111101, 6'b110111, 6'b110001, 6'b110100, 6'b110101, 6'b111001, 6'b111010, 6'b111100};
    fls = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
    rds = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    bns = 8'b0001_0110;
    grs = 8'b1100_0000;
    ogs = 8'b1110_0001;
    cls = 8'b0000_0001;
    rts = 8'b1000_0000;
    for (int k = 0; k < 8; k++) begin
      fetch_decode(ops[k], 6'd0);
      set_fields(rds[k], 2'b00, 3'b000, fls[k], bns[k], 1'b0, grs[k], ogs[k]);
      e = cyc(S_BR); e.branch = 1'b1; e.pc_we = 1'b1;
      e.call = cls[k]; e.regwrite = cls[k]; e.ret = rts[k];
      push(e, 1'b0, 1'b1, 6'd0, 6'd0);
    end
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL branch cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Zero-wait store, then loads with 10 and 14 waits: the wait counter must restart per access
  task automatic test_back_to_back();
    logic [4:0] waits [2];
    exp_t e;
    int n = 0;
    waits = '{5'd10, 5'd14};
    fetch_decode(6'b000010, 6'd0);
    set_fields(2'b00, 2'b01, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    e = cyc(S_ME); e.mem_req = 1'b1; e.memwrite = 1'b1; e.pc_we = 1'b1;
    push(e, 1'b0, 1'b1, 6'd0, 6'd0);
    for (int k = 0; k < 2; k++) begin
      fetch_decode(6'b000001, 6'd0);
      set_fields(2'b01, 2'b01, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      e = cyc(S_ME); e.mem_req = 1'b1; e.memread = 1'b1;
      for (int w = 0; w < int'(waits[k]); w++) push(e, 1'b0, 1'b0, 6'd0, 6'd0);
      push(e, 1'b0, 1'b1, 6'd0, 6'd0);
      e = cyc(S_WB); e.regwrite = 1'b1; e.pc_we = 1'b1;
      push(e, 1'b0, 1'b0, 6'd0, 6'd0);
    end
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL back_to_back cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_timeout();
    exp_t e;
    int n = 0;
    fetch_decode(6'b000010, 6'd0);
    set_fields(2'b00, 2'b01, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      e = cyc(S_ME); e.mem_req = 1'b1; e.memwrite = 1'b1;
      if (i == 15) e.pc_we = 1'b1;
      push(e, 1'b0, 1'b0, 6'd0, 6'd0);
    end
    hold.mem_tmo = 1'b1;
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
    push(cyc(S_FE), 1'b0, 1'b1, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      exp_t o;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL store_timeout cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    exp_t e;
    exp_t o;
    int n = 0;
    fetch_decode(6'b000001, 6'd0);
    set_fields(2'b01, 2'b01, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    e = cyc(S_ME); e.mem_req = 1'b1; e.memread = 1'b1;
    repeat (2) push(e, 1'b0, 1'b0, 6'd0, 6'd0);
    while (sb.size() > 0) begin
      ent_t x;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      o = obs();
      checks++;
      if (o !== x.e) $display("FAIL reset_mid_mem cycle %0d: got %h, expected %h", n, o, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) $display("FAIL reset_mid_mem pre_req: got %b, expected 1", mem_req);
    else passed++;
    rst_n = 1'b0;
    #1 o = obs();
    hold = '0;
    checks++;
    if (o !== exp_t'(0)) $display("FAIL reset_mid_mem async: got %h, expected %h", o, exp_t'(0));
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    o = obs();
    checks++;
    if (o !== exp_t'(0)) $display("FAIL reset_mid_mem after: got %h, expected %h", o, exp_t'(0));
    else passed++;
  endtask

  task automatic test_illegal();
    exp_t e;
    int n = 0;
`ifdef ILLEGAL_TRAP_EN
    exp_t o;
    fetch_decode(6'b101111, 6'd0);
    set_fields(2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    e = cyc(S_TR); e.illegal = 1'b1;
    repeat (4) push(e, 1'b1, 1'b1, 6'd0, 6'd3);
`else
    logic [5:0] ops [4];
    logic [5:0] fns [4];
    ops = '{6'b101111, 6'b000000, 6'b000000, 6'b111011};
    fns = '{6'd0, 6'd0, 6'd8, 6'd0};
    for (int k = 0; k < 4; k++) begin
      fetch_decode(ops[k], fns[k]);
      set_fields(2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      e = cyc(S_WB); e.illegal = 1'b1; e.pc_we = 1'b1;
      push(e, 1'b0, 1'b0, 6'd0, 6'd0);
    end
    push(cyc(S_FE), 1'b0, 1'b0, 6'd0, 6'd0);
`endif
    while (sb.size() > 0) begin
      ent_t x;
      exp_t ob;
      x = sb.pop_front();
      instr_valid = x.iv; mem_ready = x.mr; opcode = x.op; fn = x.fn;
      @(negedge clk);
      ob = obs();
      checks++;
      if (ob !== x.e) $display("FAIL illegal cycle %0d: got %h, expected %h", n, ob, x.e);
      else passed++;
      n++;
      @(posedge clk); #1;
    end
`ifdef ILLEGAL_TRAP_EN
    instr_valid = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    o = obs();
    checks++;
    if (o !== exp_t'(0)) $display("FAIL trap_exit: got %h, expected %h", o, exp_t'(0));
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_imm();
    test_branch();
    test_back_to_back();
    test_store_timeout();
    test_reset_mid_mem();
    test_illegal();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
